// File: rtl/bram_selftest.sv
`default_nettype none
// ============================================================================
//  Module   : bram_selftest
//  Purpose  : Built-in self test for an inferred true dual-port BRAM. A
//             controller fills every word with an address-derived pattern and
//             then reads it back. Port A handles the even addresses and port B
//             the odd addresses, so both ports work every cycle and never touch
//             the same word. The test runs either one pattern pass or a pattern
//             pass followed by an inverted pass.
//  Ports    : clk            - system clock, rising edge
//             reset          - synchronous, active-low
//             start          - one-cycle pulse, accepted in IDLE or DONE
//             mode           - 0 single pass, 1 pattern + inverted pass
//             busy           - test in progress
//             done           - test finished
//             pass           - valid with done, 1 = no mismatches
//             err_count      - saturating mismatch count
//             first_err_addr - address of the first mismatch (A wins a tie)
//             z              - 7-segment glyph {g,f,e,d,c,b,a}, active-high
//             inject         - (BRAM_SELFTEST_INJECT_EN only) corrupt one write
//             inject_addr    - (BRAM_SELFTEST_INJECT_EN only) word to corrupt
//  Options  : `define BRAM_SELFTEST_INJECT_EN adds the fault-injection ports.
//  Revision : 1.0 - initial release
// ============================================================================
module bram_selftest #(
    parameter int          DATA_W = 48,
    parameter int          ADDR_W = 10,
    parameter int          CNT_W  = 8,
    parameter logic [47:0] SEED   = 48'hA5A5_5A5A_C3C3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [6:0]        z
`ifdef BRAM_SELFTEST_INJECT_EN
   ,input  logic              inject,
    input  logic [ADDR_W-1:0] inject_addr
`endif
);

    localparam int                c_DEPTH    = 2**ADDR_W;
    localparam int                c_IW       = ADDR_W - 1;
    localparam logic [DATA_W-1:0] c_SEED     = DATA_W'(SEED);
    localparam logic [6:0]        c_SEG_OFF  = 7'b0000000;
    localparam logic [6:0]        c_SEG_DASH = 7'b1000000;
    localparam logic [6:0]        c_SEG_P    = 7'b1110011;
    localparam logic [6:0]        c_SEG_F    = 7'b1110001;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Address XOR-folded across the whole word, then seeded and optionally inverted.
    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a, input logic inv);
        logic [DATA_W-1:0] v;
        v = c_SEED;
        for (int k = 0; k * ADDR_W < DATA_W; k++) begin
            v = v ^ (DATA_W'(a) << (k * ADDR_W));
        end
        return inv ? ~v : v;
    endfunction

    logic                r_mode;
    logic                r_ph;
    logic [c_IW-1:0]     r_idx;
    logic                r_cmp_vld;
    logic [c_IW-1:0]     r_cmp_idx;
    logic                r_found;
    logic [CNT_W-1:0]    r_err_count;
    logic [ADDR_W-1:0]   r_first_err;
    logic [DATA_W-1:0]   r_mem [c_DEPTH];
    logic [DATA_W-1:0]   r_rd_a;
    logic [DATA_W-1:0]   r_rd_b;

    logic                w_last;
    logic                w_start_acc;
    logic                w_we;
    logic [ADDR_W-1:0]   w_addr_a;
    logic [ADDR_W-1:0]   w_addr_b;
    logic [DATA_W-1:0]   w_flip_a;
    logic [DATA_W-1:0]   w_flip_b;
    logic [DATA_W-1:0]   w_wdata_a;
    logic [DATA_W-1:0]   w_wdata_b;
    logic                w_mis_a;
    logic                w_mis_b;
    logic [CNT_W:0]      w_err_sum;
    logic [CNT_W-1:0]    w_err_sat;

    assign w_last   = &r_idx;
    assign w_we     = (r_state == S_FILL);
    assign w_addr_a = {r_idx, 1'b0};
    assign w_addr_b = {r_idx, 1'b1};

`ifdef BRAM_SELFTEST_INJECT_EN
    logic                r_inject;
    logic [ADDR_W-1:0]   r_inject_addr;

    // Only pass 0 is corrupted, so the inverted pass rewrites a clean word.
    assign w_flip_a = {{(DATA_W-1){1'b0}}, r_inject && !r_ph && (w_addr_a == r_inject_addr)};
    assign w_flip_b = {{(DATA_W-1){1'b0}}, r_inject && !r_ph && (w_addr_b == r_inject_addr)};
`else
    assign w_flip_a = '0;
    assign w_flip_b = '0;
`endif

    assign w_wdata_a = pat(w_addr_a, r_ph) ^ w_flip_a;
    assign w_wdata_b = pat(w_addr_b, r_ph) ^ w_flip_b;

    // Read data returns one cycle after issue; r_cmp_idx remembers which pair.
    assign w_mis_a   = r_cmp_vld && (r_rd_a != pat({r_cmp_idx, 1'b0}, r_ph));
    assign w_mis_b   = r_cmp_vld && (r_rd_b != pat({r_cmp_idx, 1'b1}, r_ph));
    assign w_err_sum = {1'b0, r_err_count} + (CNT_W+1)'(w_mis_a) + (CNT_W+1)'(w_mis_b);
    // At most two can be added, so a carry out means the count passed its maximum.
    assign w_err_sat = w_err_sum[CNT_W] ? {CNT_W{1'b1}} : w_err_sum[CNT_W-1:0];

    // Memory: no reset so contents survive a controller reset.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_addr_a] <= w_wdata_a;
            r_mem[w_addr_b] <= w_wdata_b;
        end
        r_rd_a <= r_mem[w_addr_a];
        r_rd_b <= r_mem[w_addr_b];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start_acc = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        pass        = 1'b0;
        z           = c_SEG_OFF;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_start_acc = 1'b1;
                    w_state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                busy = 1'b1;
                z    = c_SEG_DASH;
                if (w_last) w_state_nxt = S_READ;
            end
            S_READ: begin
                busy = 1'b1;
                z    = c_SEG_DASH;
                if (w_last) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                busy        = 1'b1;
                z           = c_SEG_DASH;
                w_state_nxt = (r_mode && !r_ph) ? S_FILL : S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                pass = (r_err_count == '0);
                z    = (r_err_count == '0) ? c_SEG_P : c_SEG_F;
                if (start) begin
                    w_start_acc = 1'b1;
                    w_state_nxt = S_FILL;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_mode      <= 1'b0;
            r_ph        <= 1'b0;
            r_idx       <= '0;
            r_cmp_vld   <= 1'b0;
            r_cmp_idx   <= '0;
            r_found     <= 1'b0;
            r_err_count <= '0;
            r_first_err <= '0;
`ifdef BRAM_SELFTEST_INJECT_EN
            r_inject      <= 1'b0;
            r_inject_addr <= '0;
`endif
        end else begin
            r_cmp_vld <= (r_state == S_READ);
            r_cmp_idx <= r_idx;
            if (w_start_acc) begin
                r_mode      <= mode;
                r_ph        <= 1'b0;
                r_idx       <= '0;
                r_found     <= 1'b0;
                r_err_count <= '0;
                r_first_err <= '0;
`ifdef BRAM_SELFTEST_INJECT_EN
                r_inject      <= inject;
                r_inject_addr <= inject_addr;
`endif
            end else begin
                // The index wraps to zero on the last pair, ready for the next phase.
                if (r_state == S_FILL || r_state == S_READ) begin
                    r_idx <= r_idx + 1'b1;
                end
                if (r_state == S_DRAIN && r_mode && !r_ph) begin
                    r_ph <= 1'b1;
                end
                if (w_mis_a || w_mis_b) begin
                    r_err_count <= w_err_sat;
                    if (!r_found) begin
                        r_found     <= 1'b1;
                        r_first_err <= w_mis_a ? {r_cmp_idx, 1'b0} : {r_cmp_idx, 1'b1};
                    end
                end
            end
        end
    end

    assign err_count      = r_err_count;
    assign first_err_addr = r_first_err;

endmodule
`default_nettype wire

// File: tb/tb_bram_selftest.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bram_selftest
//  Purpose  : Scoreboard bench for bram_selftest. Two instances at 16x16:
//             dut1 (8-bit error counter) and dut2 (2-bit error counter).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bram_selftest;

    localparam logic [6:0] c_SEG_OFF  = 7'b0000000;
    localparam logic [6:0] c_SEG_DASH = 7'b1000000;
    localparam logic [6:0] c_SEG_P    = 7'b1110011;
    localparam logic [6:0] c_SEG_F    = 7'b1110001;

    typedef struct {
        int         start_cyc;
        int         lat;
        logic       pass;
        int         err;
        int         first;
        logic [6:0] z;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start1 = 1'b0, mode1 = 1'b0;
    logic       start2 = 1'b0, mode2 = 1'b0;
    logic       busy1, done1, pass1, busy2, done2, pass2;
    logic [7:0] err1;
    logic [1:0] err2;
    logic [3:0] first1, first2;
    logic [6:0] z1, z2;
`ifdef BRAM_SELFTEST_INJECT_EN
    logic       inject1 = 1'b0;
    logic [3:0] inject_addr1 = 4'd0;
    logic       inject2 = 1'b0;
    logic [3:0] inject_addr2 = 4'd0;
`endif

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bram_selftest #(.DATA_W(16), .ADDR_W(4), .CNT_W(8)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .mode(mode1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_err_addr(first1), .z(z1)
`ifdef BRAM_SELFTEST_INJECT_EN
       ,.inject(inject1), .inject_addr(inject_addr1)
`endif
    );

    bram_selftest #(.DATA_W(16), .ADDR_W(4), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .mode(mode2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .first_err_addr(first2), .z(z2)
`ifdef BRAM_SELFTEST_INJECT_EN
       ,.inject(inject2), .inject_addr(inject_addr2)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic sb_cmp(input string tag, input exp_t e, input int lat, input logic p,
                          input int err, input int first, input logic [6:0] zz);
        chk({tag, "_latency"}, lat, e.lat);
        chk({tag, "_pass"}, 32'(p), 32'(e.pass));
        chk({tag, "_err_count"}, err, e.err);
        chk({tag, "_first_err_addr"}, first, e.first);
        chk({tag, "_z"}, 32'(zz), 32'(e.z));
    endtask

    // Monitors: pop an expectation on every rising edge of done.
    logic prev1 = 1'b0;
    logic prev2 = 1'b0;
    initial begin : mon1
        exp_t e;
        forever begin
            @(negedge clk);
            if (done1 && !prev1) begin
                if (q1.size() == 0) chk("dut1_unexpected_done", 32'd1, 32'd0);
                else begin
                    e = q1.pop_front();
                    sb_cmp("dut1", e, cyc - e.start_cyc, pass1, int'(err1), int'(first1), z1);
                end
            end
            prev1 = done1;
        end
    end
    initial begin : mon2
        exp_t e;
        forever begin
            @(negedge clk);
            if (done2 && !prev2) begin
                if (q2.size() == 0) chk("dut2_unexpected_done", 32'd1, 32'd0);
                else begin
                    e = q2.pop_front();
                    sb_cmp("dut2", e, cyc - e.start_cyc, pass2, int'(err2), int'(first2), z2);
                end
            end
            prev2 = done2;
        end
    end

    function automatic exp_t mk(input int lat, input logic p, input int err, input int first,
                                input logic [6:0] zz);
        exp_t e;
        e.start_cyc = 0; e.lat = lat; e.pass = p; e.err = err; e.first = first; e.z = zz;
        return e;
    endfunction

    // Pulse start for one cycle; returns at the negedge of the first busy cycle.
    task automatic go1(input logic m, input exp_t e, input logic push);
        @(negedge clk);
        start1 = 1'b1; mode1 = m;
        e.start_cyc = cyc;
        if (push) q1.push_back(e);
        @(negedge clk);
        start1 = 1'b0;
    endtask
    task automatic go2(input logic m, input exp_t e, input logic push);
        @(negedge clk);
        start2 = 1'b1; mode2 = m;
        e.start_cyc = cyc;
        if (push) q2.push_back(e);
        @(negedge clk);
        start2 = 1'b0;
    endtask

    // Counts cycles where busy/glyph are wrong before done, bounded by budget.
    task automatic wait1(input int budget, output int bad);
        int n = 0;
        bad = 0;
        while (!done1 && n < budget) begin
            if (!busy1 || z1 !== c_SEG_DASH) bad++;
            @(negedge clk);
            n++;
        end
        chk("dut1_timeout", 32'(done1), 32'd1);
    endtask
    task automatic wait2(input int budget);
        int n = 0;
        while (!done2 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("dut2_timeout", 32'(done2), 32'd1);
    endtask

    initial begin : stim
        int bad;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_done", 32'(done1), 32'd0);
        chk("rst_pass", 32'(pass1), 32'd0);
        chk("rst_err", 32'(err1), 32'd0);
        chk("rst_first", 32'(first1), 32'd0);
        chk("rst_z", 32'(z1), 32'(c_SEG_OFF));
        reset = 1'b1;
        @(negedge clk);

        // Single pass
        go1(1'b0, mk(18, 1'b1, 0, 0, c_SEG_P), 1'b1);
        wait1(60, bad);

        // Two passes; busy and '-' held for the whole run
        go1(1'b1, mk(35, 1'b1, 0, 0, c_SEG_P), 1'b1);
        wait1(80, bad);
        chk("mode1_busy_dash_whole_run", bad, 0);
        chk("mode1_busy_low_at_done", 32'(busy1), 32'd0);

        // start during FILL is ignored; the run length stays 18
        go1(1'b0, mk(18, 1'b1, 0, 0, c_SEG_P), 1'b1);
        repeat (2) @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        wait1(60, bad);

        // Restart straight from DONE
        go1(1'b0, mk(18, 1'b1, 0, 0, c_SEG_P), 1'b1);
        wait1(60, bad);

`ifdef BRAM_SELFTEST_INJECT_EN
        inject1 = 1'b1; inject_addr1 = 4'd5;
        go1(1'b1, mk(35, 1'b0, 1, 5, c_SEG_F), 1'b1);
        inject1 = 1'b0;
        wait1(80, bad);
`endif

        // dut2: corrupt words 2/3 in both passes -> 4 mismatches saturate at 3
        go2(1'b1, mk(35, 1'b0, 3, 2, c_SEG_F), 1'b1);
        repeat (4) @(negedge clk);
        dut2.r_mem[2] <= 16'h0000;
        dut2.r_mem[3] <= 16'h0000;
        repeat (17) @(negedge clk);
        dut2.r_mem[2] <= 16'h0000;
        dut2.r_mem[3] <= 16'h0000;
        wait2(80);

        // Restart from a failing DONE: counters must clear
        go2(1'b0, mk(18, 1'b1, 0, 0, c_SEG_P), 1'b1);
        wait2(60);

        // Reset in the middle of READ after a double mismatch
        go2(1'b1, mk(0, 1'b0, 0, 0, c_SEG_OFF), 1'b0);
        repeat (4) @(negedge clk);
        dut2.r_mem[2] <= 16'h0000;
        dut2.r_mem[3] <= 16'h0000;
        repeat (7) @(negedge clk);
        chk("midread_err_before_reset", 32'(err2), 32'd2);
        chk("midread_first_before_reset", 32'(first2), 32'd2);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("midreset_busy", 32'(busy2), 32'd0);
        chk("midreset_done", 32'(done2), 32'd0);
        chk("midreset_err", 32'(err2), 32'd0);
        chk("midreset_first", 32'(first2), 32'd0);
        chk("midreset_z", 32'(z2), 32'(c_SEG_OFF));
        reset = 1'b1;
        @(negedge clk);
        go2(1'b0, mk(18, 1'b1, 0, 0, c_SEG_P), 1'b1);
        wait2(60);

        repeat (2) @(negedge clk);
        chk("sb1_drained", q1.size(), 0);
        chk("sb2_drained", q2.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
